// File: rtl/cache_line_xfer.sv
// Cache-miss line mover: optional victim writeback (SRAM -> memory), then line fill (memory -> SRAM).
// Define CACHE_CRIT_WORD_FIRST_EN to start the fill at the requested word and pulse crit_valid/crit_data.

module cache_line_xfer_lane (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld_sram,
  input  logic       ld_mem,
  input  logic [7:0] sram_byte,
  input  logic [7:0] mem_byte,
  output logic [7:0] q
);
  always_ff @(posedge clk) begin
    if (!rst)         q <= '0;
    else if (ld_sram) q <= sram_byte;
    else if (ld_mem)  q <= mem_byte;
  end
endmodule

module cache_line_xfer #(
  parameter int LANES      = 4,
  parameter int LINE_WORDS = 32,
  parameter int ROW_W      = 9,
  parameter int ADDR_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_rdy,
  input  logic                  req_evict,
  input  logic [ADDR_W-1:0]     req_evict_addr,
  input  logic [ADDR_W-1:0]     req_fill_addr,
  input  logic [ROW_W-1:0]      req_row,
  output logic                  done,
  output logic                  mem_ren,
  output logic                  mem_wen,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [8*LANES-1:0]    mem_din,
  input  logic [8*LANES-1:0]    mem_dout,
  input  logic                  mem_ack,
  output logic [ROW_W-1:0]      sram_addr,
  output logic [8*LANES-1:0]    sram_din,
  input  logic [8*LANES-1:0]    sram_dout,
  output logic [LANES-1:0]      sram_sense_en,
  output logic [LANES-1:0]      sram_wen,
  output logic                  crit_valid,
  output logic [8*LANES-1:0]    crit_data
);
  localparam int CW = $clog2(LINE_WORDS);
  localparam int LB = $clog2(LANES);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << (CW + LB)) - ADDR_W'(1));
  localparam logic [ROW_W-1:0]  ROW_MASK  = ~((ROW_W'(1) << CW) - ROW_W'(1));

  typedef enum logic [2:0] {IDLE, EV_RD, EV_WR, FL_RD, FL_WR, DONE_S} state_t;

  state_t state, nxt;
  logic [CW-1:0]     cnt, cnt_nxt, start, req_start;
  logic [ADDR_W-1:0] ev_base, fl_base;
  logic [ROW_W-1:0]  row_base;
  logic              ev_first, accept, ld_sram, ld_mem;
  logic [LANES-1:0][7:0] wbuf;

`ifdef CACHE_CRIT_WORD_FIRST_EN
  assign req_start = req_fill_addr[CW+LB-1:LB];
`else
  assign req_start = '0;
`endif

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    cache_line_xfer_lane u_lane (
      .clk       (clk),
      .rst       (rst),
      .ld_sram   (ld_sram),
      .ld_mem    (ld_mem),
      .sram_byte (sram_dout[8*g +: 8]),
      .mem_byte  (mem_dout[8*g +: 8]),
      .q         (wbuf[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt      <= '0;
      start    <= '0;
      ev_base  <= '0;
      fl_base  <= '0;
      row_base <= '0;
      ev_first <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      ev_first <= (state == EV_RD);
      if (accept) begin
        ev_base  <= req_evict_addr & LINE_MASK;
        fl_base  <= req_fill_addr & LINE_MASK;
        row_base <= req_row & ROW_MASK;
        start    <= req_start;
      end
    end
  end

  always_comb begin
    nxt           = state;
    cnt_nxt       = cnt;
    accept        = 1'b0;
    ld_sram       = 1'b0;
    ld_mem        = 1'b0;
    req_rdy       = 1'b0;
    done          = 1'b0;
    mem_ren       = 1'b0;
    mem_wen       = 1'b0;
    mem_addr      = '0;
    mem_din       = '0;
    sram_addr     = '0;
    sram_din      = '0;
    sram_sense_en = '0;
    sram_wen      = '0;
    case (state)
      IDLE: begin
        req_rdy = 1'b1;
        if (req_valid) begin
          accept  = 1'b1;
          cnt_nxt = req_evict ? '0 : req_start;
          nxt     = req_evict ? EV_RD : FL_RD;
        end
      end
      EV_RD: begin
        sram_addr     = row_base + ROW_W'(cnt);
        sram_sense_en = '1;
        nxt           = EV_WR;
      end
      EV_WR: begin
        // SRAM data is only live in the first cycle; forward it then, replay the captured copy after.
        mem_wen  = 1'b1;
        mem_addr = ev_base + (ADDR_W'(cnt) << LB);
        mem_din  = ev_first ? sram_dout : wbuf;
        ld_sram  = ev_first;
        if (mem_ack) begin
          if (cnt == CW'(LINE_WORDS - 1)) begin
            cnt_nxt = start;
            nxt     = FL_RD;
          end else begin
            cnt_nxt = cnt + CW'(1);
            nxt     = EV_RD;
          end
        end
      end
      FL_RD: begin
        mem_ren  = 1'b1;
        mem_addr = fl_base + (ADDR_W'(cnt) << LB);
        if (mem_ack) begin
          ld_mem = 1'b1;
          nxt    = FL_WR;
        end
      end
      FL_WR: begin
        sram_wen  = '1;
        sram_addr = row_base + ROW_W'(cnt);
        sram_din  = wbuf;
        cnt_nxt   = cnt + CW'(1);
        // counter wraps inside the line, so returning to start means every word is written
        nxt       = (cnt_nxt == start) ? DONE_S : FL_RD;
      end
      DONE_S: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

`ifdef CACHE_CRIT_WORD_FIRST_EN
  logic fl_first, crit_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      fl_first <= 1'b0;
      crit_q   <= 1'b0;
    end else begin
      if (accept)                        fl_first <= 1'b1;
      else if (state == FL_RD && mem_ack) fl_first <= 1'b0;
      crit_q <= (state == FL_RD) && mem_ack && fl_first;
    end
  end

  assign crit_valid = crit_q;
  assign crit_data  = crit_q ? wbuf : '0;
`else
  assign crit_valid = 1'b0;
  assign crit_data  = '0;
`endif

endmodule

// File: tb/tb_cache_line_xfer.sv
// Scoreboard bench for cache_line_xfer: memory/SRAM environment models, expected beats queued at issue.
module tb_cache_line_xfer;
  localparam int LW = 32;

  logic        clk = 1'b0, rst = 1'b0;
  logic        req_valid = 1'b0, req_rdy, req_evict = 1'b0;
  logic [31:0] req_evict_addr = '0, req_fill_addr = '0;
  logic [8:0]  req_row = '0;
  logic        done, mem_ren, mem_wen, mem_ack = 1'b0;
  logic [31:0] mem_addr, mem_din, mem_dout = '0;
  logic [8:0]  sram_addr;
  logic [31:0] sram_din, sram_dout = '0;
  logic [3:0]  sram_sense_en, sram_wen;
  logic        crit_valid;
  logic [31:0] crit_data;

  cache_line_xfer dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_rdy(req_rdy), .req_evict(req_evict),
    .req_evict_addr(req_evict_addr), .req_fill_addr(req_fill_addr), .req_row(req_row),
    .done(done), .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_ack(mem_ack), .sram_addr(sram_addr), .sram_din(sram_din),
    .sram_dout(sram_dout), .sram_sense_en(sram_sense_en), .sram_wen(sram_wen),
    .crit_valid(crit_valid), .crit_data(crit_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        first;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  beat_t       beat_q[$];
  logic [31:0] crit_q[$];
  int          done_q[$];
  int          acc_q[$];
  logic [31:0] mem_m[int unsigned];
  logic [31:0] sram_m[0:511];
  logic [31:0] exp_line[0:LW-1];
  int          total = 0, bad = 0, cyc = 0, done_cnt = 0;
  bit          busy = 1'b0, ack_mode = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic finish_now();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  // unwritten memory words read back as their own byte address
  function automatic logic [31:0] memrd(logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return a;
  endfunction

  // environment: SRAM with one-cycle read latency, memory answering with a random or tied ack
  initial begin : env
    logic [3:0]  s_sense, s_wen;
    logic [8:0]  s_addr;
    logic [31:0] s_din;
    forever begin
      @(negedge clk);
      s_sense = sram_sense_en; s_wen = sram_wen; s_addr = sram_addr; s_din = sram_din;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        if (s_wen[i])   sram_m[s_addr][8*i +: 8] = s_din[8*i +: 8];
        if (s_sense[i]) sram_dout[8*i +: 8] = sram_m[s_addr][8*i +: 8];
      end
      mem_ack  = ack_mode ? 1'b1 : ($urandom_range(0, 99) < 30);
      mem_dout = mem_ren ? memrd(mem_addr) : 32'h0;
    end
  end

  initial begin : monitor
    logic        held, crit_due, p_ren, p_wen;
    logic [31:0] p_addr, p_din, e;
    beat_t       b;
    int          el, a;
    held = 0; crit_due = 0; p_ren = 0; p_wen = 0; p_addr = 0; p_din = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        held = 0; crit_due = 0;
        continue;
      end
      if (crit_due) begin
`ifdef CACHE_CRIT_WORD_FIRST_EN
        chk("crit_pulse", crit_valid, 1'b1);
`endif
        crit_due = 0;
      end
      if (crit_valid) begin
        if (crit_q.size() == 0) chk("crit_unexpected", crit_valid, 1'b0);
        else begin
          e = crit_q.pop_front();
          chk("crit_data", crit_data, e);
        end
      end
      if (held) begin
        chk("hold_ren", mem_ren, p_ren);
        chk("hold_wen", mem_wen, p_wen);
        chk("hold_addr", mem_addr, p_addr);
        if (p_wen) chk("hold_din", mem_din, p_din);
      end
      if (mem_ren || mem_wen) chk("mem_excl", mem_ren && mem_wen, 1'b0);
      if ((|sram_wen) || (|sram_sense_en)) chk("sram_excl", (|sram_wen) && (|sram_sense_en), 1'b0);
      if ((mem_ren || mem_wen) && mem_ack) begin
        if (beat_q.size() == 0) chk("beat_unexpected", mem_ren || mem_wen, 1'b0);
        else begin
          b = beat_q.pop_front();
          chk("beat_we", mem_wen, b.we);
          chk("beat_addr", mem_addr, b.addr);
          if (b.we) chk("beat_wdata", mem_din, b.data);
          if (b.first) crit_due = 1;
        end
        if (mem_wen) mem_m[mem_addr] = mem_din;
      end
      held = (mem_ren || mem_wen) && !mem_ack;
      p_ren = mem_ren; p_wen = mem_wen; p_addr = mem_addr; p_din = mem_din;
      if (req_valid && req_rdy) begin
        chk("accept_idle", busy, 1'b0);
        busy = 1'b1;
        acc_q.push_back(cyc + 1);
      end
      if (done) begin
        if (done_q.size() == 0 || acc_q.size() == 0) chk("done_unexpected", done, 1'b0);
        else begin
          el = done_q.pop_front();
          a  = acc_q.pop_front();
          if (el != 0) chk("done_latency", cyc - a + 1, el);
        end
        busy = 1'b0;
        done_cnt++;
      end
    end
  end

  function automatic void expect_xfer(bit ev, logic [31:0] ea, logic [31:0] fa, logic [8:0] row, bit lat);
    logic [31:0] eb, fb;
    logic [8:0]  rb;
    int          st, k;
    beat_t       b;
    eb = ea & ~32'h7F; fb = fa & ~32'h7F; rb = row & ~9'h1F;
    st = 0;
`ifdef CACHE_CRIT_WORD_FIRST_EN
    st = int'(fa[6:2]);
`endif
    if (ev)
      for (int j = 0; j < LW; j++) begin
        b.we = 1; b.first = 0; b.addr = eb + 4*j; b.data = sram_m[rb + j];
        beat_q.push_back(b);
      end
    for (int j = 0; j < LW; j++) begin
      k = (st + j) % LW;
      b.we = 0; b.first = (j == 0); b.addr = fb + 4*k;
      b.data = (ev && eb == fb) ? sram_m[rb + k] : memrd(fb + 4*k);
      exp_line[k] = b.data;
      beat_q.push_back(b);
    end
`ifdef CACHE_CRIT_WORD_FIRST_EN
    crit_q.push_back(exp_line[st]);
`endif
    done_q.push_back(lat ? (ev ? 129 : 65) : 0);
  endfunction

  task automatic issue(bit ev, logic [31:0] ea, logic [31:0] fa, logic [8:0] row, bit ack1, bit hold);
    int n;
    ack_mode = ack1;
    expect_xfer(ev, ea, fa, row, ack1);
    @(posedge clk); #2;
    n = 0;
    while (!req_rdy && n < 3000) begin @(posedge clk); #2; n++; end
    if (!req_rdy) begin chk("rdy_timeout", req_rdy, 1'b1); finish_now(); end
    req_valid = 1; req_evict = ev; req_evict_addr = ea; req_fill_addr = fa; req_row = row;
    if (!hold) begin
      @(posedge clk); #2;
      req_valid = 0; req_evict = 1'($urandom); req_fill_addr = $urandom; req_row = 9'($urandom);
    end
  endtask

  task automatic wait_done(int target);
    int n = 0;
    while (done_cnt < target && n < 3000) begin @(posedge clk); #2; n++; end
    if (done_cnt < target) begin chk("done_timeout", done_cnt, target); finish_now(); end
  endtask

  task automatic check_line(logic [8:0] row);
    logic [8:0] rb = row & ~9'h1F;
    for (int k = 0; k < LW; k++) chk("sram_line", sram_m[rb + k], exp_line[k]);
    chk("beats_left", beat_q.size(), 0);
  endtask

  task automatic run(bit ev, logic [31:0] ea, logic [31:0] fa, logic [8:0] row, bit ack1);
    int t = done_cnt + 1;
    issue(ev, ea, fa, row, ack1, 1'b0);
    wait_done(t);
    check_line(row);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 0; req_valid = 0;
    repeat (2) @(posedge clk);
    #2;
    beat_q.delete(); crit_q.delete(); done_q.delete(); acc_q.delete();
    busy = 0;
    chk("rst_rdy", req_rdy, 1'b1);
    chk("rst_ren", mem_ren, 1'b0);
    chk("rst_wen", mem_wen, 1'b0);
    chk("rst_sram_wen", sram_wen, 4'h0);
    chk("rst_sense", sram_sense_en, 4'h0);
    chk("rst_done", done, 1'b0);
    chk("rst_crit", crit_valid, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    rst = 1;
  endtask

  initial begin : stim
    int dc;
    for (int r = 0; r < 512; r++) sram_m[r] = $urandom;
    for (int k = 0; k < LW; k++) sram_m[32 + k] = k * 32'h01010101;
    do_reset();

    // plain fill, tied ack
    run(1'b0, 32'h0, 32'h1000, 9'd0, 1'b1);
    // writeback then fill
    run(1'b1, 32'h2000, 32'h3000, 9'd32, 1'b1);
    for (int k = 0; k < LW; k += 7) chk("evict_mem", memrd(32'h2000 + 4*k), k * 32'h01010101);
    // bursty ack, same line contents expected as the plain fill
    run(1'b0, 32'h0, 32'h1000, 9'd64, 1'b0);
    for (int k = 0; k < LW; k += 5) chk("fill_word", sram_m[64 + k], 32'h1000 + 4*k);

    // request held high across a transfer: exactly one done, then one more accept
    dc = done_cnt;
    issue(1'b0, 32'h0, 32'h1000, 9'd0, 1'b1, 1'b1);
    expect_xfer(1'b0, 32'h0, 32'h1000, 9'd0, 1'b1);
    wait_done(dc + 1);
    chk("hold_one_done", done_cnt, dc + 1);
    @(posedge clk); #2;
    req_valid = 0;
    wait_done(dc + 2);
    check_line(9'd0);

    // critical-word start offset
    run(1'b0, 32'h0, 32'h100C, 9'd96, 1'b1);
`ifndef CACHE_CRIT_WORD_FIRST_EN
    chk("crit_data_zero", crit_data, 32'h0);
`endif

    // reset in the middle of a fill aborts without done
    dc = done_cnt;
    issue(1'b0, 32'h0, 32'h1000, 9'd128, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    do_reset();
    chk("rst_no_done", done_cnt, dc);
    run(1'b0, 32'h0, 32'h1000, 9'd128, 1'b1);

    for (int i = 0; i < 6; i++) begin
      logic [31:0] ea, fa;
      ea = 32'h40000 + ($urandom_range(0, 255) << 7) + $urandom_range(0, 127);
      fa = 32'h10000 + ($urandom_range(0, 255) << 7) + $urandom_range(0, 127);
      run(1'($urandom_range(0, 1)), ea, fa, 9'($urandom_range(0, 511)), 1'($urandom_range(0, 1)));
    end

    repeat (5) @(posedge clk);
    finish_now();
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog expired at t=%0t", $time);
    bad++;
    finish_now();
  end
endmodule
